// File: rtl/vga_pkg.sv
// vga_pkg
//   Shared definitions for the VGA frame engine: the default 640x480@60
//   timing constants, helpers that derive line/frame totals, a counter
//   width helper and the sync polarity type.
package vga_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    typedef enum logic {
        ACTIVE_LOW  = 1'b0,
        ACTIVE_HIGH = 1'b1
    } sync_pol_e;

    function automatic int h_total(input int vis, input int fp, input int sw, input int bp);
        return vis + fp + sw + bp;
    endfunction

    function automatic int v_total(input int vis, input int fp, input int sw, input int bp);
        return vis + fp + sw + bp;
    endfunction

    // Width needed to hold 0..n-1; never returns 0 so that degenerate
    // counters (n == 1) still get a legal one-bit register.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// button_debounce
//   Brings a raw push-button into the clock domain through two flops and
//   filters it: the debounced level only follows the synchronised input
//   after it has differed from the current level for DEB_CYCLES cycles.
//   Ports:
//     clk        in   clock
//     rst_n      in   asynchronous active-low reset
//     button     in   raw asynchronous button, active-high
//     btn_level  out  debounced level
//     btn_press  out  one-cycle pulse when btn_level goes 0->1
module button_debounce
    import vga_pkg::*;
#(
    parameter int DEB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic btn_level,
    output logic btn_press
);

    localparam int DW = clog2_min1(DEB_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    if (DEB_CYCLES < 1) begin : g_bad_deb
        $fatal(1, "button_debounce: DEB_CYCLES must be at least 1");
    end

    logic          sync1_q, sync2_q;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == DEB_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= button;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign btn_level = level_q;
    assign btn_press = press_q;

endmodule

// File: rtl/vga_frame_engine.sv
// vga_frame_engine
//   Parametrised VGA raster timing with a frame-locked game tick and a
//   debounced button. All outputs are registered one cycle behind the
//   internal h/v counters so they stay mutually aligned.
//   Ports:
//     clk          in   pixel clock
//     rst_n        in   asynchronous active-low reset
//     tick_en      in   enables game_tick; frame count holds while low
//     button       in   raw push-button, active-high
//     HSYNC/VSYNC  out  sync pulses, asserted level = SYNC_POL
//     valid        out  pixel inside the visible area
//     curr_col     out  column, full blanking range
//     curr_row     out  row, full blanking range
//     frame_start  out  pulse at col 0, row 0
//     game_tick    out  pulse on every TICK_FRAMES-th enabled frame start
//     btn_level    out  debounced button level
//     btn_press    out  pulse on debounced press
module vga_frame_engine
    import vga_pkg::*;
#(
    parameter int        H_VISIBLE   = DEF_H_VISIBLE,
    parameter int        H_FRONT     = DEF_H_FRONT,
    parameter int        H_SYNC      = DEF_H_SYNC,
    parameter int        H_BACK      = DEF_H_BACK,
    parameter int        V_VISIBLE   = DEF_V_VISIBLE,
    parameter int        V_FRONT     = DEF_V_FRONT,
    parameter int        V_SYNC      = DEF_V_SYNC,
    parameter int        V_BACK      = DEF_V_BACK,
    parameter sync_pol_e SYNC_POL    = ACTIVE_LOW,
    parameter int        TICK_FRAMES = 1,
    parameter int        DEB_CYCLES  = 250000,
    localparam int       H_TOTAL     = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK),
    localparam int       V_TOTAL     = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK),
    localparam int       CW          = clog2_min1(H_TOTAL),
    localparam int       RW          = clog2_min1(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick_en,
    input  logic          button,
    output logic          HSYNC,
    output logic          VSYNC,
    output logic          valid,
    output logic [CW-1:0] curr_col,
    output logic [RW-1:0] curr_row,
    output logic          frame_start,
    output logic          game_tick,
    output logic          btn_level,
    output logic          btn_press
);

    if (H_VISIBLE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1) begin : g_bad_h
        $fatal(1, "vga_frame_engine: every horizontal timing field must be at least 1");
    end
    if (V_VISIBLE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_v
        $fatal(1, "vga_frame_engine: every vertical timing field must be at least 1");
    end
    if (TICK_FRAMES < 1) begin : g_bad_tick
        $fatal(1, "vga_frame_engine: TICK_FRAMES must be at least 1");
    end

    localparam int FW = clog2_min1(TICK_FRAMES);

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_VISIBLE + H_FRONT);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [RW-1:0] V_LAST   = RW'(V_TOTAL - 1);
    localparam logic [RW-1:0] V_VIS    = RW'(V_VISIBLE);
    localparam logic [RW-1:0] VS_FIRST = RW'(V_VISIBLE + V_FRONT);
    localparam logic [RW-1:0] VS_LAST  = RW'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [FW-1:0] TICK_LAST = FW'(TICK_FRAMES - 1);

    localparam logic SYNC_ON = logic'(SYNC_POL);

    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [RW-1:0] v_cnt_q, v_cnt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic          valid_q, valid_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          fs_q, fs_d;
    logic          tick_q, tick_d;

    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
    end

    // Output terms are decoded from the counters and registered, which
    // produces the one-cycle lag shared by every output.
    always_comb begin
        valid_d = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        hsync_d = ((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST)) ? SYNC_ON : ~SYNC_ON;
        vsync_d = ((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST)) ? SYNC_ON : ~SYNC_ON;
        fs_d    = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    // The frame counter only moves on the origin cycle, so a tick can never
    // land mid-frame regardless of when tick_en changes.
    always_comb begin
        fcnt_d = fcnt_q;
        tick_d = 1'b0;
        if (fs_d && tick_en) begin
            if (fcnt_q == TICK_LAST) begin
                fcnt_d = '0;
                tick_d = 1'b1;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            fcnt_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            hsync_q <= ~SYNC_ON;
            vsync_q <= ~SYNC_ON;
            fs_q    <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            fcnt_q  <= fcnt_d;
            col_q   <= h_cnt_q;
            row_q   <= v_cnt_q;
            valid_q <= valid_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            fs_q    <= fs_d;
            tick_q  <= tick_d;
        end
    end

    assign HSYNC       = hsync_q;
    assign VSYNC       = vsync_q;
    assign valid       = valid_q;
    assign curr_col    = col_q;
    assign curr_row    = row_q;
    assign frame_start = fs_q;
    assign game_tick   = tick_q;

    button_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .button    (button),
        .btn_level (btn_level),
        .btn_press (btn_press)
    );

endmodule
